// File: rtl/bus_pkg.sv
// Shared types for the CPU data-port to memory-bus bridge.
// State encoding and bus word alignment.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RDWAIT,
    DONE
  } state_e;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/data_bus_bridge_if.sv
// Wait-stated memory bus with pipelined read return.
// master = bridge side, slave = memory side.
interface data_bus_bridge_if;

  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address,
    output read,
    output write,
    output writedata,
    output byteenable,
    input  waitrequest,
    input  readdata,
    input  readdatavalid
  );

  modport slave (
    input  address,
    input  read,
    input  write,
    input  writedata,
    input  byteenable,
    output waitrequest,
    output readdata,
    output readdatavalid
  );

endinterface

// File: rtl/bus_watchdog.sv
// Transfer watchdog: cycle counter, expiry compare
// and a sticky error flag cleared only by reset.
module bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic active,
  input  logic abort,
  output logic expired,
  output logic bus_error
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | abort;
    if (clear) begin
      cnt_d = '0;
    end else if (active) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // last allowed cycle: leaving on this edge makes TIMEOUT_CYCLES in total
  assign expired   = active &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus_error = err_q;

endmodule

// File: rtl/data_bus_bridge.sv
// Converts single-cycle CPU data strobes into a wait-stated,
// pipelined-read bus transfer, stalling the CPU meanwhile.
module data_bus_bridge
  import bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         data_address,
  input  logic                data_read,
  input  logic                data_write,
  input  logic [31:0]         data_writedata,
  input  logic [3:0]          byte_enable,
  output logic [31:0]         data_readdata,
  output logic                cpu_stall,
  data_bus_bridge_if.master   avm,
  output logic                bus_error
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        wr_q, wr_d;
  logic [31:0] rdata_q, rdata_d;

  logic req, in_req, active;
  logic clear, abort, expired;
  logic stall;

  assign req    = data_read | data_write;
  assign in_req = (state_q == REQ);
  assign active = in_req || (state_q == RDWAIT);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    stall   = 1'b1;
    clear   = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall = req;
        if (req) begin
          addr_d  = data_address & WORD_MASK;
          wdata_d = data_writedata;
          be_d    = byte_enable;
          wr_d    = data_write;
          clear   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (!avm.waitrequest) begin
          if (wr_q) begin
            state_d = DONE;
          end else if (avm.readdatavalid) begin
            rdata_d = avm.readdata;
            state_d = DONE;
          end else begin
            state_d = RDWAIT;
          end
        end else if (expired) begin
          abort   = 1'b1;
          state_d = DONE;
          if (!wr_q) rdata_d = '0;
        end
      end
      RDWAIT: begin
        if (avm.readdatavalid) begin
          rdata_d = avm.readdata;
          state_d = DONE;
        end else if (expired) begin
          abort   = 1'b1;
          rdata_d = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        stall   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  end

  bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_wdog (
    .clk       (clk),
    .rst_n     (reset),
    .clear     (clear),
    .active    (active),
    .abort     (abort),
    .expired   (expired),
    .bus_error (bus_error)
  );

  // fields are only driven while a request is on the bus
  assign avm.read       = in_req && !wr_q;
  assign avm.write      = in_req && wr_q;
  assign avm.address    = in_req ? addr_q : '0;
  assign avm.writedata  = in_req ? wdata_q : '0;
  assign avm.byteenable = in_req ? be_q : '0;

  assign data_readdata = rdata_q;
  assign cpu_stall     = stall;

endmodule

// File: tb/tb_data_bus_bridge.sv
// Directed plus randomized bench for data_bus_bridge
// against a transaction-level timing model.
module tb_data_bus_bridge;

  localparam int T = 8;

  logic        clk;
  logic        reset;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [3:0]  byte_enable;
  logic [31:0] data_readdata;
  logic        cpu_stall;
  logic        bus_error;

  data_bus_bridge_if avm_if ();

  data_bus_bridge #(
    .TIMEOUT_CYCLES (T),
    .CNT_W          (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .data_address   (data_address),
    .data_read      (data_read),
    .data_write     (data_write),
    .data_writedata (data_writedata),
    .byte_enable    (byte_enable),
    .data_readdata  (data_readdata),
    .cpu_stall      (cpu_stall),
    .avm            (avm_if),
    .bus_error      (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] last_rd = '0;
  logic        err_m   = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    data_read  = 1'b0;
    data_write = 1'b0;
    avm_if.waitrequest   = 1'b0;
    avm_if.readdatavalid = 1'b0;
    #1;
    chk("idle_stall", cpu_stall, 0);
    @(negedge clk);
  endtask

  // One CPU transfer; the bench plays the bus slave.
  // nwait: cycles of waitrequest; vdelay: cycles from accept to valid.
  task automatic xfer(input bit wr, input bit both,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be,
                      input int nwait, input int vdelay,
                      input logic [31:0] rdat);
    int c, nreq, nact, a;
    bit to, onbus;
    logic [31:0] exp_rd;
    c      = wr ? nwait : nwait + vdelay;
    nreq   = (nwait + 1 < T) ? nwait + 1 : T;
    to     = (c >= T);
    nact   = to ? T : c + 1;
    exp_rd = wr ? last_rd : (to ? 32'h0 : rdat);
    data_address   = addr;
    data_write     = wr;
    data_read      = !wr || both;
    data_writedata = wd;
    byte_enable    = be;
    for (int j = 0; j <= nact + 1; j++) begin
      a     = j - 1;
      onbus = (j >= 1) && (a < nreq);
      avm_if.waitrequest   = (j >= 1) && (a < nwait);
      avm_if.readdatavalid = !wr && !to && (j >= 1) && (a == c);
      avm_if.readdata = avm_if.readdatavalid ? rdat : $urandom;
      #1;
      chk("stall", cpu_stall, (j <= nact) ? 1 : 0);
      chk("avm_read", avm_if.read, onbus && !wr);
      chk("avm_write", avm_if.write, onbus && wr);
      chk("rw_excl", avm_if.read & avm_if.write, 0);
      if (onbus) begin
        chk("avm_addr", avm_if.address, {addr[31:2], 2'b00});
        chk("avm_be", avm_if.byteenable, be);
        if (wr) chk("avm_wdata", avm_if.writedata, wd);
      end
      if (j == nact + 1) begin
        chk("readdata", data_readdata, exp_rd);
        chk("bus_error", bus_error, err_m | to);
      end
      @(negedge clk);
    end
    last_rd = exp_rd;
    err_m   = err_m | to;
  endtask

  initial begin
    reset = 1'b0;
    data_address = '0;
    data_read = 1'b0;
    data_write = 1'b0;
    data_writedata = '0;
    byte_enable = '0;
    avm_if.waitrequest = 1'b0;
    avm_if.readdata = '0;
    avm_if.readdatavalid = 1'b0;
    #3;
    chk("rst_stall", cpu_stall, 0);
    chk("rst_read", avm_if.read, 0);
    chk("rst_write", avm_if.write, 0);
    chk("rst_addr", avm_if.address, 0);
    chk("rst_rdata", data_readdata, 0);
    chk("rst_err", bus_error, 0);
    @(negedge clk);
    reset = 1'b1;

    xfer(1, 0, 32'h0000_1007, 32'hA5A5_5A5A, 4'hF, 0, 0, 0);
    idle();
    xfer(0, 0, 32'h0000_2002, 0, 4'h3, 3, 2, 32'h1234_5678);
    idle();
    xfer(0, 0, 32'h0000_3000, 0, 4'hC, 0, 0, 32'hCAFE_F00D);
    xfer(0, 0, 32'h0000_4004, 0, 4'hF, 1, 1, 32'h0BAD_BEEF);
    xfer(1, 1, 32'h0000_4008, 32'h5555_AAAA, 4'h1, 0, 0, 0);
    idle();
    xfer(0, 0, 32'h0000_5000, 0, 4'hF, 20, 0, 32'hDEAD_DEAD);
    xfer(1, 0, 32'h0000_5004, 32'h0F0F_0F0F, 4'hF, 1, 0, 0);
    xfer(0, 0, 32'h0000_5008, 0, 4'hF, 0, 8, 32'h7777_7777);
    xfer(0, 0, 32'h0000_500C, 0, 4'hF, 0, 7, 32'h6666_6666);
    idle();

    for (int i = 0; i < 24; i++) begin
      xfer($urandom_range(0, 1), $urandom_range(0, 1),
           $urandom, $urandom, 4'($urandom),
           $urandom_range(0, 9), $urandom_range(0, 4), $urandom);
      if ($urandom_range(0, 1) == 1) idle();
    end

    data_address = 32'h0000_6000;
    data_read    = 1'b1;
    data_write   = 1'b0;
    avm_if.waitrequest   = 1'b0;
    avm_if.readdatavalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rdwait_read", avm_if.read, 0);
    chk("rdwait_stall", cpu_stall, 1);
    data_read = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    chk("arst_stall", cpu_stall, 0);
    chk("arst_read", avm_if.read, 0);
    chk("arst_write", avm_if.write, 0);
    chk("arst_rdata", data_readdata, 0);
    chk("arst_err", bus_error, 0);
    @(negedge clk);
    reset   = 1'b1;
    last_rd = '0;
    err_m   = 1'b0;
    xfer(0, 0, 32'h0000_7003, 0, 4'hF, 1, 1, 32'h89AB_CDEF);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
